// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: PC, ROM addressing, one-entry output stage, redirects and halt.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/redirect counters.
module instr_fetch_sequencer #(
    parameter logic [29:0] RESET_PC    = 30'd0,
    parameter bit          HALT_ON_END = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [29:0] rom_address,
    input  logic [31:0] rom_instruction,
    input  logic        rom_mem_end,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [29:0] out_pc,
    input  logic        redirect_valid,
    input  logic [29:0] redirect_target,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [15:0] redirect_count,
`endif
    output logic        busy,
    output logic        halted
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

    state_t      state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [29:0] out_pc_q, out_pc_d;

    logic end_hit;
    logic load;
    logic redirect_acc;
    logic handshake;

    assign end_hit      = HALT_ON_END && rom_mem_end;
    assign load         = (state_q == ST_RUN) && !(out_valid_q && !out_ready) && !end_hit;
    assign redirect_acc = redirect_valid && (state_q != ST_IDLE);
    assign handshake    = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;

        if (handshake) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A redirect flushes the stage and suppresses this cycle's fetch.
                if (redirect_valid) begin
                    pc_d        = redirect_target;
                    out_valid_d = 1'b0;
                end else if (end_hit) begin
                    state_d = ST_HALT;
                end else if (load) begin
                    out_instr_d = rom_instruction;
                    out_pc_d    = pc_q;
                    out_valid_d = 1'b1;
                    pc_d        = pc_q + 30'd1;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    pc_d        = redirect_target;
                    out_valid_d = 1'b0;
                    state_d     = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'd0;
            out_pc_q    <= 30'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [31:0] fetch_cnt_q;
    logic [15:0] redir_cnt_q;

    // Counters survive start; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            redir_cnt_q <= 16'd0;
        end else begin
            if (handshake && !redirect_acc) begin
                fetch_cnt_q <= sat_inc32(fetch_cnt_q);
            end
            if (redirect_acc) begin
                redir_cnt_q <= sat_inc16(redir_cnt_q);
            end
        end
    end

    assign fetch_count    = fetch_cnt_q;
    assign redirect_count = redir_cnt_q;
`endif

    assign rom_address     = pc_q;
    assign out_valid       = out_valid_q;
    assign out_instruction = out_instr_q;
    assign out_pc          = out_pc_q;
    assign busy            = (state_q == ST_RUN);
    assign halted          = (state_q == ST_HALT);

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Sequences the combinational word-addressed instruction ROM (30-bit word address in; 32-bit instruction and mem_end out).
- Holds the program counter and drives the ROM address.
- Registers each fetched word into a one-entry output stage with a valid/ready handshake to decode.
- Accepts branch/jump redirects from execute, and halts when the ROM reports end of program.

Parameters:
RESET_PC, 0, word address loaded into PC on reset and on start
HALT_ON_END, 1, 1: enter HALT when rom_mem_end is seen; 0: ignore rom_mem_end and keep fetching (default ROM word is 0)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; leaves IDLE and begins fetching at RESET_PC
rom_address  output  30  word address to the instruction ROM; always equals pc
rom_instruction  input  32  combinational ROM data for rom_address
rom_mem_end  input  1  ROM flag: rom_address is past the last program word
out_valid  output  1  output stage holds a valid instruction
out_ready  input  1  decode accepts the output stage this cycle
out_instruction  output  32  registered instruction
out_pc  output  30  word address the registered instruction was fetched from
redirect_valid  input  1  execute requests a PC change (taken branch/jump)
redirect_target  input  30  new word address
busy  output  1  state is RUN
halted  output  1  state is HALT

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, pc=RESET_PC, out_valid=0, out_instruction=0, out_pc=0, busy=0, halted=0. Reset wins over every other input in the same cycle, including mid-fetch and mid-redirect. The output stage is discarded.
- rom_address = pc at all times, combinationally. The ROM is combinational, so fetch latency is one cycle: the word at pc is captured at the next edge.
- Load condition: load = (state==RUN) && !(out_valid && !out_ready) && !end_hit, where end_hit = HALT_ON_END && rom_mem_end.
- On load: out_instruction<=rom_instruction, out_pc<=pc, out_valid<=1, pc<=pc+1.
- PC arithmetic: pc+1 is modulo 2^30; 30'h3FFFFFFF wraps to 0 with no flag.
- Consume without refill (out_valid && out_ready && !load): out_valid<=0.
- Steady state: with out_ready held high, one instruction per cycle.
- Backpressure: while out_valid && !out_ready, the output stage and pc hold.
- State machine (priority: reset > redirect > normal):
  - IDLE: start -> pc<=RESET_PC, RUN. Other inputs ignored, including redirect_valid.
  - RUN: redirect_valid -> pc<=redirect_target, out_valid<=0 (the flushed word is not presented). A redirect coincident with out_ready is treated as the handshake completing; the stage is still cleared. No load occurs in the redirect cycle; the first post-redirect word is valid one cycle later (redirect bubble = 1 cycle).
  - RUN: end_hit with no redirect -> HALT. pc is held at the end address. An already-valid output stage is kept until consumed.
  - HALT: redirect_valid -> pc<=redirect_target, RUN. This allows a branch still in flight to resume. start is ignored.
  - HALT exits only by reset or redirect.
- start pulses while in RUN or HALT are ignored.
- busy=(state==RUN); halted=(state==HALT); both registered from state.
- Once out_valid is high, out_instruction and out_pc are stable until the handshake completes or a redirect/reset occurs.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_count[31:0]: increments on every handshake (out_valid && out_ready) with no redirect in the same cycle.
  - Adds output redirect_count[15:0]: increments on every accepted redirect, in RUN or HALT.
  - Both are cleared by reset, not by start, and saturate at all-ones.
- Not defined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, start, out_ready=1, ROM words 0..12 with rom_mem_end=1 above 12, no redirects -> out_valid at cycle 2 with out_pc=0; out_pc 0..12 in consecutive cycles; halted=1 with pc=13; out_valid=0 after the last consume.
- Backpressure: out_ready=0 for 3 cycles while out_pc=4 -> out_instruction and out_pc hold the address-4 word, pc holds at 5. out_ready=1 -> next out_pc=5 with no skip or duplicate.
- Redirect to 5 asserted while out_pc=11 is valid and out_ready=1 -> next cycle out_valid=0; following cycle out_pc=5; the word at 12 is never presented.
- In HALT at pc=13, redirect_target=12 -> RUN, out_pc=12. A self-jump redirect to 12 every time 12 is consumed -> 12 is presented every 2 cycles, halted stays 0.
- RESET_PC=30'h3FFFFFFE, HALT_ON_END=0 -> out_pc sequence 3FFFFFFE, 3FFFFFFF, 0, 1.
- Reset asserted mid-stream with out_valid=1 and redirect_valid=1 -> next cycle out_valid=0, state IDLE, pc=RESET_PC. With FETCH_PERF_CNT_EN, both counters read 0.
